// File: rtl/conv_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : conv_mem_server
// Description : Weight/feature/result store serving the conv2d engine on R
//               row lanes, with an arbitrated host preload/readback port.
//               Optional macro CONV_MEM_OOB_CHECK_EN adds sticky err_o and
//               drops out-of-range engine writes instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mem_server #(
    parameter int DW = 16,
    parameter int R  = 3,
    parameter int H  = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [DW-1:0]   raddr_i,
    input  logic            addr_is_weight_i,
    input  logic            rd_en_i,
    output logic [R*DW-1:0] rdata_o,
    output logic            rvalid_o,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW-1:0]   waddr_i,
    input  logic            wen_i,
    input  logic            busy_i,
    input  logic            host_valid_i,
    output logic            host_ready_o,
    input  logic [1:0]      host_op_i,
    input  logic [DW-1:0]   host_addr_i,
    input  logic [DW-1:0]   host_wdata_i,
    output logic [DW-1:0]   host_rdata_o,
    output logic            host_rvalid_o
`ifdef CONV_MEM_OOB_CHECK_EN
    ,
    output logic            err_o
`endif
);
    localparam int unsigned FD  = H * H;
    localparam int unsigned WD  = R * R;
    localparam int          AW  = $clog2(FD);
    localparam int          WAW = $clog2(WD);
    localparam logic [31:0] C_R  = 32'(R);
    localparam logic [31:0] C_H  = 32'(H);
    localparam logic [31:0] C_FD = 32'(FD);
    localparam logic [31:0] C_WD = 32'(WD);

    localparam logic [1:0]  C_OP_WFEAT = 2'd0;
    localparam logic [1:0]  C_OP_WWGT  = 2'd1;
    localparam logic [1:0]  C_OP_RRES  = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST_ACT = 2'd1,
        ENG_ACT  = 2'd2
    } state_t;

    state_t r_state;

    logic [DW-1:0] r_wgt  [WD];
    logic [DW-1:0] r_feat [FD];
    logic [DW-1:0] r_res  [FD];

    logic [31:0]     w_raddr;
    logic [31:0]     w_waddr;
    logic [31:0]     w_haddr;
    logic [31:0]     w_idx;
    logic [R*DW-1:0] w_rdata;
    logic            w_rd_oob;
    logic            w_wr_oob;
    logic            w_host_oob;
    logic            w_host_xfer;
    logic            w_host_rd;

    assign w_raddr = 32'(raddr_i);
    assign w_waddr = 32'(waddr_i);
    assign w_haddr = 32'(host_addr_i);

    assign host_ready_o = !busy_i && (r_state != ENG_ACT);
    assign w_host_xfer  = host_valid_i && host_ready_o;
    assign w_host_rd    = w_host_xfer && (host_op_i == C_OP_RRES);

    assign w_rd_oob = addr_is_weight_i ? (w_raddr >= C_R) : (w_raddr >= C_FD);
    assign w_wr_oob = (w_waddr >= C_FD);

    always_comb begin
        case (host_op_i)
            C_OP_WFEAT, C_OP_RRES: w_host_oob = (w_haddr >= C_FD);
            C_OP_WWGT:             w_host_oob = (w_haddr >= C_WD);
            default:               w_host_oob = 1'b0;
        endcase
    end

    // Lane l reads one row further down; rows past the bottom read as zero.
    always_comb begin
        w_rdata = '0;
        w_idx   = '0;
        for (int l = 0; l < R; l++) begin
            if (addr_is_weight_i) begin
                w_idx = 32'(l) * C_R + w_raddr;
                if (w_raddr < C_R)
                    w_rdata[l*DW +: DW] = r_wgt[WAW'(w_idx)];
            end else begin
                w_idx = 32'(l) * C_H + w_raddr;
                if (w_idx < C_FD)
                    w_rdata[l*DW +: DW] = r_feat[AW'(w_idx)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (busy_i)
                        r_state <= ENG_ACT;
                    else if (host_valid_i)
                        r_state <= HOST_ACT;
                end
                HOST_ACT: begin
                    if (busy_i)
                        r_state <= ENG_ACT;
                    else if (!host_valid_i)
                        r_state <= IDLE;
                end
                ENG_ACT: begin
                    if (!busy_i)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately unreset so preloaded contents survive rstn_i.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            if (wen_i) begin
`ifdef CONV_MEM_OOB_CHECK_EN
                if (!w_wr_oob)
                    r_res[AW'(w_waddr)] <= wdata_i;
`else
                r_res[AW'(w_waddr % C_FD)] <= wdata_i;
`endif
            end
            if (w_host_xfer && !w_host_oob) begin
                if (host_op_i == C_OP_WFEAT)
                    r_feat[AW'(w_haddr)] <= host_wdata_i;
                else if (host_op_i == C_OP_WWGT)
                    r_wgt[WAW'(w_haddr)] <= host_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_o       <= '0;
            rvalid_o      <= 1'b0;
            host_rdata_o  <= '0;
            host_rvalid_o <= 1'b0;
        end else begin
            rvalid_o      <= rd_en_i;
            host_rvalid_o <= w_host_rd;
            if (rd_en_i)
                rdata_o <= w_rdata;
            if (w_host_rd)
                host_rdata_o <= w_host_oob ? '0 : r_res[AW'(w_haddr)];
        end
    end

`ifdef CONV_MEM_OOB_CHECK_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            err_o <= 1'b0;
        else if ((rd_en_i && w_rd_oob) || (wen_i && w_wr_oob) ||
                 (w_host_xfer && w_host_oob))
            err_o <= 1'b1;
    end
`endif

endmodule
`default_nettype wire
